// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM data-memory arbiter.
package arm_mem_pkg;

  // Arbiter ownership state: free arbitration or locked to one master
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // Master identifiers, also used as the read-tracker owner tag
  localparam logic MID_CPU = 1'b0;
  localparam logic MID_DMA = 1'b1;

  // Deepest memory read latency the tracker supports
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/arb_rd_tracker.sv
// Read-return tracker: an RD_LAT-deep shift register of {valid, owner}.
// A push in the grant cycle emerges as rvalid for that owner exactly
// RD_LAT cycles later. Reset drops every outstanding read.
module arb_rd_tracker
  import arm_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic owner,
  output logic rvalid0,
  output logic rvalid1
);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("arb_rd_tracker: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
  end

  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [RD_LAT-1:0] owner_q, owner_d;

  // Shift the pipeline by one stage; stage 0 takes the new read
  always_comb begin
    valid_d    = valid_q;
    owner_d    = owner_q;
    valid_d[0] = push;
    owner_d[0] = owner;
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      owner_d[i] = owner_q[i-1];
    end
  end

  // Pipeline registers, cleared on reset so no stale rvalid survives
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  // Decode the last stage into per-master valids, silenced while in reset
  always_comb begin
    rvalid0 = !reset && valid_q[RD_LAT-1] && (owner_q[RD_LAT-1] == MID_CPU);
    rvalid1 = !reset && valid_q[RD_LAT-1] && (owner_q[RD_LAT-1] == MID_DMA);
  end

endmodule

// File: rtl/arm_dmem_arbiter.sv
// Two-master arbiter for a single-port data RAM (M0 = CPU, M1 = DMA).
// Zero-cycle grant, lock support for atomic read-modify-write, and
// fixed-latency read return via arb_rd_tracker.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin in IDLE instead of
// fixed M0 priority.
module arm_dmem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [3:0]    m0_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [3:0]    m1_be,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t state_q, state_d;
  logic       prefer0;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q names the master favoured on the next contested IDLE cycle
  logic rr_q, rr_d;

  // Hand priority to the other master after every IDLE grant
  always_comb begin
    rr_d    = rr_q;
    prefer0 = (rr_q == MID_CPU);
    if (state_q == IDLE && m0_gnt) rr_d = MID_DMA;
    if (state_q == IDLE && m1_gnt) rr_d = MID_CPU;
  end

  // Round-robin pointer; reset favours the CPU
  always_ff @(posedge clk) begin
    if (reset) rr_q <= MID_CPU;
    else       rr_q <= rr_d;
  end
`else
  // Fixed priority: the CPU always wins a contested IDLE cycle
  always_comb prefer0 = 1'b1;
`endif

  // Grant decision and next ownership state
  always_comb begin
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    state_d = state_q;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (m0_req && (!m1_req || prefer0)) m0_gnt = 1'b1;
          else if (m1_req)                    m1_gnt = 1'b1;
          if (m0_gnt && m0_lock) state_d = LOCK0;
          if (m1_gnt && m1_lock) state_d = LOCK1;
        end
        LOCK0: begin
          m0_gnt = m0_req;
          if (!m0_req || !m0_lock) state_d = IDLE;
        end
        LOCK1: begin
          m1_gnt = m1_req;
          if (!m1_req || !m1_lock) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Ownership state register; reset releases any lock
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Memory port mux: follows the granted master, otherwise idles on M0 fields
  always_comb begin
    mem_en    = m0_gnt | m1_gnt;
    mem_we    = m1_gnt ? m1_we : (m0_gnt & m0_we);
    mem_be    = reset ? 4'b0000 : (m1_gnt ? m1_be : m0_be);
    mem_addr  = m1_gnt ? m1_addr  : m0_addr;
    mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
    m0_rdata  = mem_rdata;
    m1_rdata  = mem_rdata;
  end

  arb_rd_tracker #(
    .RD_LAT (RD_LAT)
  ) u_rd_tracker (
    .clk     (clk),
    .reset   (reset),
    .push    (mem_en & ~mem_we),
    .owner   (m1_gnt),
    .rvalid0 (m0_rvalid),
    .rvalid1 (m1_rvalid)
  );

endmodule

// File: tb/tb_arm_dmem_arbiter.sv
// Self-checking bench for arm_dmem_arbiter. Two instances share stimulus:
// u_dut_a (RD_LAT=1) and u_dut_b (RD_LAT=2). A transaction-level model
// (lock owner, last winner, queues of read due-times) predicts every cycle.
module tb_arm_dmem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;

  logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic        a_mem_en, a_mem_we;
  logic [3:0]  a_mem_be;
  logic [31:0] a_mem_addr, a_mem_wdata;

  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_mem_en, b_mem_we;
  logic [3:0]  b_mem_be;
  logic [31:0] b_mem_addr, b_mem_wdata;

  always #5 clk = ~clk;

  arm_dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_be(m0_be),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_be(m1_be),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata)
  );

  arm_dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(2)) u_dut_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_be(m0_be),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_be(m1_be),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata)
  );

  // Scoreboard counters and model state
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int locked = -1;     // master holding the lock, -1 if none
  int last_win = 1;    // last IDLE winner; 1 makes M0 favoured after reset
  int g1_seen = 0;     // observed M1 grants, for the contention test
  int g_model = -1;    // model's grant in the cycle just evaluated
  int qa0[$], qa1[$], qb0[$], qb1[$];  // due cycles of outstanding reads

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit due_now(input int q[$], input int c);
    return (q.size() > 0) && (q[0] == c);
  endfunction

  // Predict this cycle from the current inputs, compare, then advance the model
  task automatic model_cycle();
    int g;
    logic ewe;
    logic [3:0] ebe;
    logic [31:0] eaddr, ewd;
    bit ea0, ea1, eb0, eb1;
    g = -1;
    if (!reset) begin
      if (locked == 0)      g = m0_req ? 0 : -1;
      else if (locked == 1) g = m1_req ? 1 : -1;
      else if (m0_req && m1_req) g = (RR && last_win == 0) ? 1 : 0;
      else if (m0_req) g = 0;
      else if (m1_req) g = 1;
    end
    ewe   = (g == 1) ? m1_we : ((g == 0) ? m0_we : 1'b0);
    eaddr = (g == 1) ? m1_addr : m0_addr;
    ewd   = (g == 1) ? m1_wdata : m0_wdata;
    ebe   = reset ? 4'b0000 : ((g == 1) ? m1_be : m0_be);
    ea0 = !reset && due_now(qa0, cyc);
    ea1 = !reset && due_now(qa1, cyc);
    eb0 = !reset && due_now(qb0, cyc);
    eb1 = !reset && due_now(qb1, cyc);

    check_val("a_m0_gnt", a_m0_gnt, g == 0);
    check_val("a_m1_gnt", a_m1_gnt, g == 1);
    check_val("b_m0_gnt", b_m0_gnt, g == 0);
    check_val("b_m1_gnt", b_m1_gnt, g == 1);
    check_val("mem_en", a_mem_en, g >= 0);
    check_val("mem_we", a_mem_we, ewe);
    check_val("mem_be", a_mem_be, ebe);
    check_val("mem_addr", a_mem_addr, eaddr);
    check_val("mem_wdata", a_mem_wdata, ewd);
    check_val("a_m0_rvalid", a_m0_rvalid, ea0);
    check_val("a_m1_rvalid", a_m1_rvalid, ea1);
    check_val("b_m0_rvalid", b_m0_rvalid, eb0);
    check_val("b_m1_rvalid", b_m1_rvalid, eb1);
    if (ea0) check_val("a_m0_rdata", a_m0_rdata, mem_rdata);
    if (ea1) check_val("a_m1_rdata", a_m1_rdata, mem_rdata);
    if (eb0) check_val("b_m0_rdata", b_m0_rdata, mem_rdata);
    if (eb1) check_val("b_m1_rdata", b_m1_rdata, mem_rdata);

    if (a_m1_gnt) g1_seen++;
    if (g >= 0)
      $display("cyc %0d: M%0d %s addr=%08h be=%b wdata=%08h lock=%0d",
               cyc, g, ewe ? "WR" : "RD", eaddr, ebe, ewd, (g == 1) ? m1_lock : m0_lock);

    if (due_now(qa0, cyc)) void'(qa0.pop_front());
    if (due_now(qa1, cyc)) void'(qa1.pop_front());
    if (due_now(qb0, cyc)) void'(qb0.pop_front());
    if (due_now(qb1, cyc)) void'(qb1.pop_front());

    if (reset) begin
      locked = -1;
      last_win = 1;
      qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete();
    end else begin
      if (g == 0 && !ewe) begin qa0.push_back(cyc + 1); qb0.push_back(cyc + 2); end
      if (g == 1 && !ewe) begin qa1.push_back(cyc + 1); qb1.push_back(cyc + 2); end
      if (locked >= 0) begin
        if (locked == 0 && (!m0_req || !m0_lock)) locked = -1;
        else if (locked == 1 && (!m1_req || !m1_lock)) locked = -1;
      end else if (g >= 0) begin
        last_win = g;
        if ((g == 0 && m0_lock) || (g == 1 && m1_lock)) locked = g;
      end
    end
    g_model = g;
    cyc++;
  endtask

  // Inputs are already applied (1 ns after the edge); evaluate mid-cycle
  task automatic run_cycle();
    #3;
    model_cycle();
    @(posedge clk);
    #1;
    mem_rdata = $urandom;
  endtask

  // Random protocol-legal stimulus for one master
  task automatic gen(input bit granted, inout logic req, inout logic we, inout logic lock,
                     inout logic [3:0] be, inout logic [31:0] addr, inout logic [31:0] wdata);
    if (granted || !req) begin
      req = $urandom_range(0, 1) != 0;
      if (req) begin
        we    = $urandom_range(0, 1) != 0;
        lock  = $urandom_range(0, 3) == 0;
        be    = 4'($urandom);
        addr  = {22'd0, 8'($urandom), 2'b00};
        wdata = $urandom;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      req = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_be = 4'hF; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_be = 4'hF; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    run_cycle();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    mem_rdata = 32'h0;
    idle_inputs();
    @(posedge clk);
    #1;
    // Reset state: no grant, no strobe, be zero
    #3;
    check_val("rst_mem_en", a_mem_en, 1'b0);
    check_val("rst_mem_be", a_mem_be, 4'b0000);
    check_val("rst_gnt", {a_m0_gnt, a_m1_gnt}, 2'b00);
    #0;
    @(posedge clk);
    #1;
    reset = 0;

    // Lone M0 read at 0x100
    m0_req = 1; m0_addr = 32'h100;
    run_cycle();
    m0_req = 0;
    run_cycle();
    run_cycle();

    // Both masters contend for four cycles
    do_reset();
    g1_seen = 0;
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
    repeat (4) run_cycle();
    check_val("contend_m1_gnts", 64'(g1_seen), RR ? 64'd2 : 64'd0);
    idle_inputs();
    run_cycle();

    // Locked read-modify-write by M1 blocks M0
    do_reset();
    m1_req = 1; m1_addr = 32'h40; m1_lock = 1;
    run_cycle();
    m1_we = 1; m1_wdata = 32'hDEADBEEF; m1_lock = 0;
    m0_req = 1; m0_addr = 32'h80;
    #2;
    check_val("lock_blocks_m0", a_m0_gnt, 1'b0);
    run_cycle();
    m1_req = 0;
    #2;
    check_val("m0_after_unlock", a_m0_gnt, 1'b1);
    run_cycle();
    idle_inputs();
    repeat (3) run_cycle();

    // Back-to-back reads from different masters
    m0_req = 1; m0_addr = 32'h300;
    run_cycle();
    m0_req = 0; m1_req = 1; m1_addr = 32'h304;
    run_cycle();
    m1_req = 0;
    repeat (3) run_cycle();

    // Reset one cycle after a read discards it
    m0_req = 1; m0_addr = 32'h400;
    run_cycle();
    m0_req = 0;
    do_reset();
    repeat (3) run_cycle();

    // M0 partial write
    m0_req = 1; m0_we = 1; m0_addr = 32'h200; m0_be = 4'b0011; m0_wdata = 32'h12345678;
    #2;
    check_val("wr_mem_be", a_mem_be, 4'b0011);
    run_cycle();
    idle_inputs();
    repeat (3) run_cycle();

    // Randomised traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      run_cycle();
      gen(g_model == 0, m0_req, m0_we, m0_lock, m0_be, m0_addr, m0_wdata);
      gen(g_model == 1, m1_req, m1_we, m1_lock, m1_be, m1_addr, m1_wdata);
    end
    reset = 0;
    idle_inputs();
    repeat (4) run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
